// File: rtl/axi_wr_burst_engine.sv
// Write-side AXI4 master: turns burst/tail requests into one AW/W/B transaction each,
// draining a first-word-fall-through FIFO and tracking the running frame address.
module axi_wr_burst_engine #(
  parameter int ASIZE  = 32,
  parameter int DSIZE  = 64,
  parameter int LSIZE  = 9,
  parameter int AXI_ID = 0
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [ASIZE-1:0]   base_addr,
  input  logic               burst_req,
  input  logic               tail_req,
  input  logic [LSIZE-1:0]   req_len,
  output logic               resp,
  output logic               done,
  input  logic               rst_chain,
  input  logic               fifo_empty,
  input  logic [DSIZE-1:0]   fifo_data,
  output logic               fifo_rd_en,
  output logic [3:0]         awid,
  output logic [ASIZE-1:0]   awaddr,
  output logic [7:0]         awlen,
  output logic [2:0]         awsize,
  output logic [1:0]         awburst,
  output logic               awvalid,
  input  logic               awready,
  output logic [DSIZE-1:0]   wdata,
  output logic [DSIZE/8-1:0] wstrb,
  output logic               wlast,
  output logic               wvalid,
  input  logic               wready,
  input  logic               bvalid,
  input  logic [1:0]         bresp,
  output logic               bready,
  output logic               err
);

  localparam int BYTES  = DSIZE / 8;
  localparam int BSHIFT = $clog2(BYTES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]       state;
  logic [LSIZE-1:0] len;
  logic [LSIZE-1:0] len_m1;
  logic [LSIZE-1:0] beat_cnt;
  logic [LSIZE-1:0] beat_nxt;
  logic [ASIZE-1:0] addr;
  logic [ASIZE-1:0] fs_base;
  logic             fs_pending;
  logic             abort_r;
  logic             awvalid_r;
  logic [7:0]       awlen_r;
  logic             wlast_r;
  logic             bready_r;
  logic             resp_r;
  logic             done_r;
  logic             err_r;
  logic             req_any;
  logic             aw_hs;
  logic             w_hs;
  logic             b_hs;

  assign req_any  = burst_req | tail_req;
  assign len_m1   = len - LSIZE'(1);
  assign beat_nxt = beat_cnt + LSIZE'(1);

  assign aw_hs = awvalid_r & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bready_r & bvalid;

  assign awid    = 4'(AXI_ID);
  assign awaddr  = addr;
  assign awlen   = awlen_r;
  assign awsize  = 3'(BSHIFT);
  assign awburst = 2'b01;
  assign awvalid = awvalid_r;

  // While aborting, W beats keep flowing without the FIFO so the burst still closes legally.
  assign wdata      = fifo_data;
  assign wvalid     = (state == S_W) & (abort_r | ~fifo_empty);
  assign fifo_rd_en = wvalid & wready & ~abort_r;
  assign wstrb      = {BYTES{~abort_r}};
  assign wlast      = wlast_r;

  assign bready = bready_r;
  assign resp   = resp_r;
  assign done   = done_r;
  assign err    = err_r;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len       <= '0;
      beat_cnt  <= '0;
      awvalid_r <= 1'b0;
      awlen_r   <= '0;
      wlast_r   <= 1'b0;
      bready_r  <= 1'b0;
      resp_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      resp_r <= 1'b0;
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_any) begin
            len     <= req_len;
            awlen_r <= 8'(req_len - LSIZE'(1));
            resp_r  <= 1'b1;
            if (req_len == '0) begin
              state <= S_FIN;
            end else begin
              state     <= S_AW;
              awvalid_r <= 1'b1;
            end
          end
        end
        S_AW: begin
          if (aw_hs) begin
            awvalid_r <= 1'b0;
            beat_cnt  <= '0;
            wlast_r   <= (len == LSIZE'(1));
            state     <= S_W;
          end
        end
        S_W: begin
          if (w_hs) begin
            beat_cnt <= beat_nxt;
            if (wlast_r) begin
              wlast_r  <= 1'b0;
              bready_r <= 1'b1;
              state    <= S_B;
            end else begin
              wlast_r <= (beat_nxt == len_m1);
            end
          end
        end
        S_B: begin
          if (b_hs) begin
            bready_r <= 1'b0;
            state    <= S_FIN;
          end
        end
        S_FIN: begin
          done_r <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A frame_start seen mid-transaction is parked and applied once the engine is idle again.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      err_r      <= 1'b0;
      fs_pending <= 1'b0;
      fs_base    <= '0;
    end else if (state == S_IDLE) begin
      if (frame_start) begin
        addr       <= base_addr;
        err_r      <= 1'b0;
        fs_pending <= 1'b0;
      end else if (fs_pending) begin
        addr       <= fs_base;
        err_r      <= 1'b0;
        fs_pending <= 1'b0;
      end
    end else begin
      if (frame_start) begin
        fs_pending <= 1'b1;
        fs_base    <= base_addr;
      end
      if ((state == S_B) && b_hs && (bresp != 2'b00)) begin
        err_r <= 1'b1;
      end
      if ((state == S_FIN) && !abort_r) begin
        addr <= addr + (ASIZE'(len) << BSHIFT);
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      abort_r <= 1'b0;
    end else if (state == S_FIN) begin
      abort_r <= 1'b0;
    end else if (rst_chain && ((state == S_AW) || (state == S_W) || (state == S_B))) begin
      abort_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_wr_burst_engine.sv
// Scoreboard bench for axi_wr_burst_engine: stimulus queues expected AW/W/resp/done events,
// a negedge monitor pops and compares them as the DUT handshakes.
module tb_axi_wr_burst_engine;

  localparam int ASIZE = 32;
  localparam int DSIZE = 64;
  localparam int LSIZE = 9;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        rd;
  } beat_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_start = 1'b0;
  logic [31:0]      base_addr = '0;
  logic             burst_req = 1'b0;
  logic             tail_req = 1'b0;
  logic [LSIZE-1:0] req_len = '0;
  logic             resp;
  logic             done;
  logic             rst_chain = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [63:0]      fifo_data = '0;
  logic             fifo_rd_en;
  logic [3:0]       awid;
  logic [31:0]      awaddr;
  logic [7:0]       awlen;
  logic [2:0]       awsize;
  logic [1:0]       awburst;
  logic             awvalid;
  logic             awready = 1'b1;
  logic [63:0]      wdata;
  logic [7:0]       wstrb;
  logic             wlast;
  logic             wvalid;
  logic             wready = 1'b1;
  logic             bvalid = 1'b0;
  logic [1:0]       bresp = 2'b00;
  logic             bready;
  logic             err;

  axi_wr_burst_engine #(.ASIZE(ASIZE), .DSIZE(DSIZE), .LSIZE(LSIZE), .AXI_ID(0)) dut (
    .clock(clock), .rst_n(rst_n), .frame_start(frame_start), .base_addr(base_addr),
    .burst_req(burst_req), .tail_req(tail_req), .req_len(req_len), .resp(resp), .done(done),
    .rst_chain(rst_chain), .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bresp(bresp), .bready(bready), .err(err)
  );

  always #5 clock = ~clock;

  beat_t       exp_w[$];
  aw_t         exp_aw[$];
  logic [63:0] fifoq[$];

  int vectors = 0;
  int miscompares = 0;
  int resp_out = 0;
  int done_out = 0;
  int aw_open = 0;
  int w_beats = 0;
  int pops = 0;
  int pop_req = 0, pop_done = 0;
  int b_arm_req = 0, b_arm_done = 0;
  int b_ack_req = 0, b_ack_done = 0;
  int b_wait = 0;
  int test_no = 0;
  bit rand_mode = 1'b0;
  bit starve = 1'b0;
  bit prev_aw_stall = 1'b0;
  logic [31:0] prev_aw_addr = '0;
  logic [1:0]  next_bresp = 2'b00;
  logic [31:0] exp_addr = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] word(input int t, input int i);
    return {16'hC0DE, 16'(t), 32'(i)};
  endfunction

  // Environment: FIFO model, ready randomisation and a B responder two cycles after wlast.
  always @(posedge clock) begin
    #1;
    if (!rst_n) begin
      bvalid = 1'b0;
      bresp = 2'b00;
      b_wait = 0;
      pop_done = pop_req;
      b_arm_done = b_arm_req;
      b_ack_done = b_ack_req;
    end
    while (pop_done < pop_req) begin
      if (fifoq.size() > 0) fifoq.delete(0);
      pop_done++;
    end
    if (rand_mode) begin
      awready = 1'($urandom_range(0, 1));
      wready = 1'($urandom_range(0, 1));
      starve = ($urandom_range(0, 3) == 0);
    end else begin
      awready = 1'b1;
      wready = 1'b1;
      starve = 1'b0;
    end
    if (b_ack_done < b_ack_req) begin
      bvalid = 1'b0;
      bresp = 2'b00;
      b_ack_done = b_ack_req;
    end
    if (b_arm_done < b_arm_req) begin
      b_arm_done = b_arm_req;
      b_wait = 2;
    end
    if (b_wait > 0) begin
      b_wait--;
      if (b_wait == 0) begin
        bvalid = 1'b1;
        bresp = next_bresp;
      end
    end
    #1;
    fifo_empty = starve || (fifoq.size() == 0);
    fifo_data = (fifoq.size() > 0) ? fifoq[0] : 64'h0;
  end

  // Monitor: every handshake is checked against the scoreboard queues.
  always @(negedge clock) begin
    if (rst_n) begin
      if (resp) begin
        checkOutput("resp_expected", 64'(resp_out > 0), 64'd1);
        checkOutput("done_not_with_resp", 64'(done), 64'd0);
        if (resp_out > 0) resp_out--;
      end
      if (done) begin
        checkOutput("done_expected", 64'(done_out > 0), 64'd1);
        if (done_out > 0) done_out--;
      end
      if (wvalid && wready) begin
        checkOutput("w_after_aw", 64'(aw_open > 0), 64'd1);
        if (exp_w.size() == 0) begin
          checkOutput("w_unexpected", 64'd1, 64'd0);
        end else begin
          beat_t e;
          e = exp_w.pop_front();
          checkOutput("wdata", wdata, e.data);
          checkOutput("wstrb", 64'(wstrb), 64'(e.strb));
          checkOutput("wlast", 64'(wlast), 64'(e.last));
          checkOutput("fifo_rd_en", 64'(fifo_rd_en), 64'(e.rd));
        end
        w_beats++;
        if (wlast) begin
          b_arm_req++;
          if (aw_open > 0) aw_open--;
        end
      end
      if (prev_aw_stall) begin
        checkOutput("aw_valid_held", 64'(awvalid), 64'd1);
        checkOutput("aw_addr_stable", 64'(awaddr), 64'(prev_aw_addr));
      end
      prev_aw_stall = awvalid && !awready;
      prev_aw_addr = awaddr;
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) begin
          checkOutput("aw_unexpected", 64'd1, 64'd0);
        end else begin
          aw_t a;
          a = exp_aw.pop_front();
          checkOutput("awaddr", 64'(awaddr), 64'(a.addr));
          checkOutput("awlen", 64'(awlen), 64'(a.len));
          checkOutput("awsize", 64'(awsize), 64'd3);
          checkOutput("awburst", 64'(awburst), 64'd1);
          checkOutput("awid", 64'(awid), 64'd0);
        end
        aw_open++;
      end
      if (fifo_rd_en) begin
        checkOutput("pop_needs_handshake", 64'(wvalid && wready), 64'd1);
        pops++;
        pop_req++;
      end
      if (fifo_empty) checkOutput("wvalid_while_empty", 64'(wvalid), 64'd0);
      if (bvalid && bready) b_ack_req++;
    end
  end

  task automatic frameStart(input logic [31:0] base);
    @(posedge clock); #1;
    base_addr = base;
    frame_start = 1'b1;
    @(posedge clock); #1;
    frame_start = 1'b0;
    exp_addr = base;
    @(negedge clock); #1;
    checkOutput("err_after_frame_start", 64'(err), 64'd0);
  endtask

  // kind: 0 burst, 1 tail, 2 both. abort_after < 0 means no abort.
  task automatic applyStimulus(input int kind, input int len, input logic [1:0] br,
                               input int abort_after, input bit mid_frame, input logic [31:0] new_base);
    int pops0, beats0, lat, exp_pops;
    bit got;
    test_no++;
    pops0 = pops;
    beats0 = w_beats;
    exp_pops = (abort_after < 0) ? len : abort_after;
    @(posedge clock); #1;
    next_bresp = br;
    for (int i = 0; i < len; i++) begin
      fifoq.push_back(word(test_no, i));
      if (abort_after < 0 || i < abort_after)
        exp_w.push_back('{data: word(test_no, i), strb: 8'hFF, last: (i == len - 1), rd: 1'b1});
      else
        exp_w.push_back('{data: word(test_no, abort_after), strb: 8'h00, last: (i == len - 1), rd: 1'b0});
    end
    if (len > 0) exp_aw.push_back('{addr: exp_addr, len: 8'(len - 1)});
    resp_out++;
    done_out++;
    req_len = LSIZE'(len);
    burst_req = (kind != 1);
    tail_req = (kind != 0);
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clock); #1;
      if (resp) got = 1'b1;
      else lat++;
    end
    checkOutput("resp_latency", 64'(got ? lat : 99), 64'd1);
    @(posedge clock); #1;
    burst_req = 1'b0;
    tail_req = 1'b0;
    if (abort_after >= 0) begin
      got = 1'b0;
      for (int c = 0; c < 2000 && !got; c++) begin
        if (w_beats - beats0 >= abort_after - 1) got = 1'b1;
        else begin @(negedge clock); #1; end
      end
      checkOutput("abort_point_reached", 64'(got), 64'd1);
      @(posedge clock); #1;
      rst_chain = 1'b1;
      @(posedge clock); #1;
      rst_chain = 1'b0;
    end
    if (mid_frame) begin
      repeat (4) @(posedge clock);
      #1;
      base_addr = new_base;
      frame_start = 1'b1;
      @(posedge clock); #1;
      frame_start = 1'b0;
      @(negedge clock); #1;
      checkOutput("err_held_while_pending", 64'(err), 64'd1);
    end
    got = 1'b0;
    for (int c = 0; c < 5000 && !got; c++) begin
      @(negedge clock); #1;
      if (done) got = 1'b1;
    end
    checkOutput("done_seen", 64'(got), 64'd1);
    checkOutput("pop_count", 64'(pops - pops0), 64'(exp_pops));
    checkOutput("beats_left", 64'(exp_w.size()), 64'd0);
    if (mid_frame) exp_addr = new_base;
    else if (abort_after < 0) exp_addr = exp_addr + 32'(len * 8);
    @(posedge clock); #1;
    fifoq.delete();
    next_bresp = 2'b00;
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #3;
    checkOutput("rst_awvalid", 64'(awvalid), 64'd0);
    checkOutput("rst_wvalid", 64'(wvalid), 64'd0);
    checkOutput("rst_wlast", 64'(wlast), 64'd0);
    checkOutput("rst_bready", 64'(bready), 64'd0);
    checkOutput("rst_resp", 64'(resp), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    #19 rst_n = 1'b1;

    frameStart(32'h1000);
    applyStimulus(0, 100, 2'b00, -1, 1'b0, '0);
    checkOutput("addr_after_burst", 64'(exp_addr), 64'h1320);
    applyStimulus(1, 37, 2'b00, -1, 1'b0, '0);
    applyStimulus(2, 5, 2'b00, -1, 1'b0, '0);

    rand_mode = 1'b1;
    applyStimulus(0, 20, 2'b00, -1, 1'b0, '0);
    rand_mode = 1'b0;

    applyStimulus(0, 8, 2'b10, -1, 1'b0, '0);
    checkOutput("err_set", 64'(err), 64'd1);
    repeat (4) @(posedge clock);
    @(negedge clock);
    checkOutput("err_sticky", 64'(err), 64'd1);

    applyStimulus(0, 16, 2'b00, -1, 1'b1, 32'h8000);
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("err_cleared_by_frame", 64'(err), 64'd0);

    applyStimulus(0, 100, 2'b00, 10, 1'b0, '0);
    applyStimulus(0, 0, 2'b00, -1, 1'b0, '0);
    applyStimulus(0, 4, 2'b00, -1, 1'b0, '0);
    applyStimulus(1, 3, 2'b11, -1, 1'b0, '0);
    checkOutput("err_set_again", 64'(err), 64'd1);

    test_no++;
    for (int i = 0; i < 50; i++) fifoq.push_back(word(test_no, i));
    exp_aw.push_back('{addr: exp_addr, len: 8'd49});
    for (int i = 0; i < 50; i++)
      exp_w.push_back('{data: word(test_no, i), strb: 8'hFF, last: (i == 49), rd: 1'b1});
    resp_out++;
    req_len = LSIZE'(50);
    burst_req = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    burst_req = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    checkOutput("wvalid_before_reset", 64'(wvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_awvalid", 64'(awvalid), 64'd0);
    checkOutput("mid_rst_wvalid", 64'(wvalid), 64'd0);
    checkOutput("mid_rst_wlast", 64'(wlast), 64'd0);
    checkOutput("mid_rst_bready", 64'(bready), 64'd0);
    checkOutput("mid_rst_resp", 64'(resp), 64'd0);
    checkOutput("mid_rst_done", 64'(done), 64'd0);
    checkOutput("mid_rst_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
    checkOutput("mid_rst_err", 64'(err), 64'd0);
    exp_aw.delete();
    exp_w.delete();
    fifoq.delete();
    resp_out = 0;
    done_out = 0;
    aw_open = 0;
    prev_aw_stall = 1'b0;
    @(posedge clock); #3;
    rst_n = 1'b1;
    exp_addr = '0;
    applyStimulus(0, 4, 2'b00, -1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/axi_wr_burst_engine.md
Name: axi_wr_burst_engine

Overview:
- Write-side AXI4 master stage that sits directly downstream of the FIFO status controller.
- Accepts burst/tail requests (req + length) and answers with one-cycle resp and done pulses.
- Drains beats from the first-word-fall-through write FIFO onto AW/W/B channels.
- Maintains the running frame write address.

Parameters:
ASIZE, 32, AXI address width
DSIZE, 64, AXI data width (power of 2, >=8)
LSIZE, 9, request length width (beats); legal req_len range 0..256
AXI_ID, 0, constant awid value

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  pulse; reload address from base_addr, clear err
base_addr  in  ASIZE  frame base byte address (DSIZE/8 aligned)
burst_req  in  1  level; full-burst request, held until resp
tail_req  in  1  level; tail request, held until resp
req_len  in  LSIZE  beats for current request, valid with req
resp  out  1  pulse; request accepted
done  out  1  pulse; request fully written (B received)
rst_chain  in  1  pulse; abort, flush current request
fifo_empty  in  1  FWFT FIFO empty
fifo_data  in  DSIZE  FWFT FIFO head word
fifo_rd_en  out  1  pop FIFO head
awid  out  4  = AXI_ID
awaddr  out  ASIZE  burst start address
awlen  out  8  req_len-1
awsize  out  3  log2(DSIZE/8)
awburst  out  2  constant 2'b01 (INCR)
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  DSIZE  = fifo_data
wstrb  out  DSIZE/8  all ones; all zeros while aborting
wlast  out  1  last beat
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  B valid
bresp  in  2  B response
bready  out  1  B ready
err  out  1  sticky: any bresp != 0 since last frame_start

Behaviour:
- Reset (async): state IDLE; addr = 0; awvalid, wvalid, wlast, bready, resp, done, fifo_rd_en, err, abort flag = 0.
- States: IDLE, AW, W, B, FIN.
- IDLE, with burst_req or tail_req high:
  - Latch len = req_len.
  - Pulse resp for exactly one cycle.
  - If len==0: go to FIN (no AXI traffic). Otherwise go to AW.
  - burst_req and tail_req are mutually exclusive from upstream. If both are high, tail_req wins.
- AW:
  - awvalid=1; awaddr = addr; awlen = len-1 (low 8 bits).
  - awvalid and awaddr stay stable until the awready handshake.
  - On handshake: go to W; beat counter = 0.
- W:
  - wvalid = !fifo_empty (or 1 while aborting).
  - fifo_rd_en = wvalid & wready & !abort.
  - wlast = (beat counter == len-1).
  - Each handshake increments the beat counter.
  - On the handshake with wlast: go to B.
  - No W beat is ever issued before the AW handshake.
- B:
  - bready=1. On bvalid: if bresp!=0, set err; go to FIN.
- FIN:
  - Pulse done for one cycle.
  - addr += len*(DSIZE/8), modulo 2^ASIZE; skipped when aborting.
  - Go to IDLE; clear abort.
  - Earliest re-accept is the cycle after FIN, so resp latency from req is 1 cycle (registered resp on the IDLE->AW transition).
- frame_start:
  - In IDLE: addr = base_addr next cycle; err cleared.
  - In any other state: latched as pending and applied on return to IDLE, before the next request is accepted.
  - The err clear is applied at the same time as the address reload.
- rst_chain:
  - In IDLE: ignored.
  - In AW/W/B: set abort. The AXI transaction completes legally: W beats drive wstrb=0, FIFO is not read, wvalid is held at 1 regardless of fifo_empty.
  - done still pulses. addr is not advanced.
- AXI rules:
  - valid is never dropped without a handshake.
  - Outputs come from registers except wdata/wvalid/fifo_rd_en, which are combinational from FIFO status inside W.
- req_len > 256 is illegal; awlen uses the low 8 bits of len-1 (not checked).

Test Plan:
- Burst: base_addr=0x1000, frame_start, burst_req with req_len=100, FIFO full, awready/wready tied 1, bvalid 2 cycles after wlast, bresp=0 -> resp 1 cycle after req; awaddr=0x1000, awlen=99; 100 beats with wlast on beat 100; done 1 cycle after B; next awaddr=0x1320.
- Tail: tail_req with req_len=37 after the previous test -> awlen=36, 37 beats, next address 0x1320+37*8=0x1448; both requests asserted together -> tail_len used.
- Backpressure: random awready/wready, FIFO running empty mid-burst -> wvalid low while empty; no pops without handshake; awaddr stable while awvalid && !awready; exactly len pops.
- Error/frame: bresp=2'b10 on one burst -> err=1 and held; frame_start mid-burst with base_addr=0x8000 -> applied only after done; next awaddr=0x8000; err=0.
- Abort: rst_chain at beat 10 of 100 -> remaining 90 beats have wstrb=0, fifo_rd_en stays low, done pulses, addr unchanged.
- Zero/reset: req_len=0 -> resp then done, no awvalid; rst_n low mid-W -> all outputs 0 immediately; state IDLE.
